// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants, receive FSM state type and the
// reflected CRC-32 byte update used by both the receiver and transmitter.
package eth_pkg;

    localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
    localparam logic [3:0]  SFD_NIB      = 4'hD;
    localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB20E3;
    localparam int unsigned HDR_BYTES    = 14;
    localparam int unsigned FCS_BYTES    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_PAY,
        ST_CHECK,
        ST_DROP
    } rx_state_t;

    // LSB-first bit-serial update, unrolled to one byte per call.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
            else                c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide CRC-32 register: synchronous init has priority over a byte update.
module crc32_d8
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    crc <= CRC_INIT;
        else if (init) crc <= CRC_INIT;
        else if (en)   crc <= crc32_byte(crc, data);
    end

endmodule

// File: rtl/rgmii_frame_rx.sv
// Nibble-stream Ethernet receiver: strips preamble/SFD, filters on MAC and
// EtherType, writes payload into a circular buffer and commits on good FCS.
module rgmii_frame_rx
    import eth_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR    = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned MAX_PAYLOAD = 1500
) (
    input  logic              rxclk,
    input  logic              rst_n,
    input  logic [3:0]        rxd,
    input  logic              rxctl,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] commit_ptr,
    output logic              frame_done,
    output logic              frame_ok,
    output logic [15:0]       frame_len,
    output logic [15:0]       good_cnt,
    output logic [15:0]       err_cnt
);

    localparam logic [15:0]       PAY_LIMIT = 16'(MAX_PAYLOAD + FCS_BYTES);
    localparam logic [15:0]       MIN_FRAME = 16'(HDR_BYTES + FCS_BYTES);
    localparam logic [15:0]       LAST_HDR  = 16'(HDR_BYTES - 1);
    localparam logic [15:0]       FCS_LEN16 = 16'(FCS_BYTES);
    localparam logic [ADDR_W-1:0] FCS_LEN   = ADDR_W'(FCS_BYTES);

    rx_state_t         state, state_nxt;
    logic              nib_phase;
    logic [3:0]        low_nib;
    logic [7:0]        byte_r;
    logic              byte_vld;
    logic [15:0]       byte_cnt;
    logic [15:0]       pay_cnt;
    logic [47:0]       dst_r;
    logic [7:0]        type_hi;
    logic [ADDR_W-1:0] ptr;
    logic              drop_err;
    logic [31:0]       crc;
    logic              capture, filter_ok, pay_full, fault_drop, frame_good;

    assign capture    = (state == ST_HDR || state == ST_PAY) && rxctl;
    assign filter_ok  = (dst_r == MAC_ADDR || dst_r == '1) && ({type_hi, byte_r} == ETHERTYPE);
    assign pay_full   = byte_vld && (pay_cnt == PAY_LIMIT);
    assign frame_good = (crc == CRC_RESIDUE) && !nib_phase && (byte_cnt >= MIN_FRAME);

    crc32_d8 u_crc (
        .clk   (rxclk),
        .rst_n (rst_n),
        .init  (state == ST_IDLE),
        .en    (byte_vld),
        .data  (byte_r),
        .crc   (crc)
    );

    always_ff @(posedge rxclk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        fault_drop = 1'b0;
        case (state)
            ST_IDLE: if (rxctl && rxd == PREAMBLE_NIB) state_nxt = ST_PRE;
            ST_PRE: begin
                if (!rxctl || (rxd != PREAMBLE_NIB && rxd != SFD_NIB)) begin
                    state_nxt  = ST_DROP;
                    fault_drop = 1'b1;
                end else if (rxd == SFD_NIB) begin
                    state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                if (!rxctl)
                    state_nxt = ST_CHECK;
                else if (byte_vld && byte_cnt == LAST_HDR)
                    state_nxt = filter_ok ? ST_PAY : ST_DROP;
            end
            ST_PAY: begin
                // Overflow wins over a simultaneous rxctl fall so the oversize byte is never written.
                if (pay_full) begin
                    state_nxt  = ST_DROP;
                    fault_drop = 1'b1;
                end else if (!rxctl) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: state_nxt = ST_IDLE;
            ST_DROP:  if (!rxctl) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge rxclk or negedge rst_n) begin
        if (!rst_n) begin
            nib_phase  <= 1'b0;
            low_nib    <= '0;
            byte_r     <= '0;
            byte_vld   <= 1'b0;
            byte_cnt   <= '0;
            pay_cnt    <= '0;
            dst_r      <= '0;
            type_hi    <= '0;
            ptr        <= '0;
            drop_err   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            commit_ptr <= '0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            frame_len  <= '0;
            good_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;

            if (capture) begin
                if (!nib_phase) low_nib <= rxd;
                else            byte_r  <= {rxd, low_nib};
                nib_phase <= ~nib_phase;
            end else if (state == ST_IDLE || state == ST_PRE) begin
                nib_phase <= 1'b0;
            end
            byte_vld <= capture && nib_phase;

            if (state == ST_IDLE) begin
                byte_cnt <= '0;
                pay_cnt  <= '0;
                drop_err <= 1'b0;
            end else if (byte_vld && (state == ST_HDR || state == ST_PAY)) begin
                byte_cnt <= byte_cnt + 16'd1;
            end

            if (byte_vld && state == ST_HDR) begin
                if (byte_cnt < 16'd6)   dst_r   <= {dst_r[39:0], byte_r};
                if (byte_cnt == 16'd12) type_hi <= byte_r;
            end

            if (fault_drop) drop_err <= 1'b1;

            if (state == ST_PAY && byte_vld && !pay_full) begin
                wr_en   <= 1'b1;
                wr_addr <= ptr;
                wr_data <= byte_r;
                ptr     <= ptr + 1'b1;
                pay_cnt <= pay_cnt + 16'd1;
            end

            if (state == ST_CHECK) begin
                frame_done <= 1'b1;
                if (frame_good) begin
                    // Committing before the FCS lets the next frame overwrite those 4 bytes.
                    frame_ok   <= 1'b1;
                    frame_len  <= pay_cnt - FCS_LEN16;
                    commit_ptr <= ptr - FCS_LEN;
                    ptr        <= ptr - FCS_LEN;
                    if (good_cnt != '1) good_cnt <= good_cnt + 16'd1;
                end else begin
                    frame_ok <= 1'b0;
                    ptr      <= commit_ptr;
                    if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
                end
            end

            if (state == ST_DROP && !rxctl) begin
                ptr <= commit_ptr;
                if (drop_err) begin
                    frame_done <= 1'b1;
                    frame_ok   <= 1'b0;
                    if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rgmii_frame_rx.sv
// Scoreboard bench for rgmii_frame_rx: directed frames push expected writes and
// end-of-frame status; a negedge monitor pops and compares what the DUT presents.
module tb_rgmii_frame_rx;

    localparam int unsigned ADDR_W = 14;
    localparam logic [47:0] BCAST  = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] MYMAC  = 48'h02_00_00_00_00_01;

    logic              rxclk = 1'b0;
    logic              rst_n = 1'b0;
    logic [3:0]        rxd   = '0;
    logic              rxctl = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [ADDR_W-1:0] commit_ptr;
    logic              frame_done;
    logic              frame_ok;
    logic [15:0]       frame_len;
    logic [15:0]       good_cnt;
    logic [15:0]       err_cnt;

    rgmii_frame_rx #(
        .MAC_ADDR    (MYMAC),
        .ETHERTYPE   (16'h88B5),
        .ADDR_W      (ADDR_W),
        .MAX_PAYLOAD (1500)
    ) dut (
        .rxclk      (rxclk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .rxctl      (rxctl),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit_ptr (commit_ptr),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .frame_len  (frame_len),
        .good_cnt   (good_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 rxclk = ~rxclk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    typedef struct {
        logic              ok;
        logic [15:0]       len;
        logic [ADDR_W-1:0] commit;
        logic [15:0]       good;
        logic [15:0]       err;
    } done_t;

    wr_t        wr_q[$];
    done_t      done_q[$];
    logic [7:0] frm[$];
    int         errors = 0;
    int         checks = 0;
    int         m_commit = 0, m_len = 0, m_good = 0, m_err = 0;
    wr_t        w_exp;
    done_t      d_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(negedge rxclk) begin
        if (rst_n) begin
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, required none", wr_addr, wr_data);
                end else begin
                    w_exp = wr_q.pop_front();
                    check("wr_addr", 64'(wr_addr), 64'(w_exp.addr));
                    check("wr_data", 64'(wr_data), 64'(w_exp.data));
                end
            end
            if (frame_done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got frame_done ok=%0d, required none", frame_ok);
                end else begin
                    d_exp = done_q.pop_front();
                    check("frame_ok",   64'(frame_ok),   64'(d_exp.ok));
                    check("frame_len",  64'(frame_len),  64'(d_exp.len));
                    check("commit_ptr", 64'(commit_ptr), 64'(d_exp.commit));
                    check("good_cnt",   64'(good_cnt),   64'(d_exp.good));
                    check("err_cnt",    64'(err_cnt),    64'(d_exp.err));
                end
            end
        end
    end

    // Reference FCS: standard LSB-first CRC-32 with final inversion.
    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        logic        fb;
        logic [7:0]  b;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            b = frm[i];
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic build(input logic [47:0] dst, input logic [15:0] typ, input int plen, input bit flip);
        logic [47:0] src;
        logic [31:0] fcs;
        src = 48'h02_00_00_00_00_99;
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(src[47-8*i -: 8]);
        frm.push_back(typ[15:8]);
        frm.push_back(typ[7:0]);
        for (int i = 0; i < plen; i++) frm.push_back(8'(i));
        fcs = fcs_of(frm.size());
        for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
        if (flip) frm[19] = frm[19] ^ 8'h10;
    endtask

    task automatic drive_nib(input logic [3:0] n);
        @(negedge rxclk);
        rxctl = 1'b1;
        rxd   = n;
    endtask

    task automatic send(input int n_nib, input bit finish);
        logic [7:0] b;
        for (int i = 0; i < 15; i++) drive_nib(4'h5);
        drive_nib(4'hD);
        for (int i = 0; i < n_nib; i++) begin
            b = frm[i/2];
            drive_nib((i % 2) ? b[7:4] : b[3:0]);
        end
        if (finish) begin
            @(negedge rxclk);
            rxctl = 1'b0;
            rxd   = '0;
            repeat (24) @(negedge rxclk);
        end
    endtask

    task automatic exp_writes(input int n);
        for (int i = 0; i < n; i++)
            wr_q.push_back('{addr: ADDR_W'((m_commit + i) % 16384), data: frm[14+i]});
    endtask

    task automatic exp_done(input bit ok, input int plen);
        if (ok) begin
            m_len    = plen;
            m_commit = (m_commit + plen) % 16384;
            m_good++;
        end else begin
            m_err++;
        end
        done_q.push_back('{ok: ok, len: 16'(m_len), commit: ADDR_W'(m_commit),
                           good: 16'(m_good), err: 16'(m_err)});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},      64'(wr_en),      0);
        check({tag, "_wr_addr"},    64'(wr_addr),    0);
        check({tag, "_wr_data"},    64'(wr_data),    0);
        check({tag, "_commit_ptr"}, 64'(commit_ptr), 0);
        check({tag, "_frame_done"}, 64'(frame_done), 0);
        check({tag, "_frame_ok"},   64'(frame_ok),   0);
        check({tag, "_frame_len"},  64'(frame_len),  0);
        check({tag, "_good_cnt"},   64'(good_cnt),   0);
        check({tag, "_err_cnt"},    64'(err_cnt),    0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge rxclk);
        rst_n = 1'b1;
        @(negedge rxclk);
        check_all_zero("reset");

        // Corrupted payload bit: written, then rewound; commit stays 0.
        build(BCAST, 16'h88B5, 46, 1'b1);
        exp_writes(50);
        exp_done(1'b0, 0);
        send(128, 1'b1);

        // Good broadcast frame lands at address 0.
        build(BCAST, 16'h88B5, 46, 1'b0);
        exp_writes(50);
        exp_done(1'b1, 46);
        send(128, 1'b1);
        check("commit_after_good", 64'(commit_ptr), 64'd46);

        // Silent filter drops: MAC miss, then EtherType miss.
        build(48'h02_02_02_02_02_02, 16'h88B5, 46, 1'b0);
        send(128, 1'b1);
        build(BCAST, 16'h0800, 46, 1'b0);
        send(128, 1'b1);
        check("filter_good_cnt", 64'(good_cnt), 64'(m_good));
        check("filter_err_cnt",  64'(err_cnt),  64'(m_err));

        // Odd nibble count: all bytes written, frame rejected.
        build(BCAST, 16'h88B5, 46, 1'b0);
        frm.push_back(8'hA5);
        exp_writes(50);
        exp_done(1'b0, 0);
        send(129, 1'b1);

        // 10-byte runt ends inside the header.
        build(BCAST, 16'h88B5, 46, 1'b0);
        exp_done(1'b0, 0);
        send(20, 1'b1);
        check("runt_err_cnt", 64'(err_cnt), 64'd3);

        // 1501-byte payload: 1504 writes, then dropped with error at rxctl fall.
        build(BCAST, 16'h88B5, 1501, 1'b0);
        exp_writes(1504);
        exp_done(1'b0, 0);
        send(2 * frm.size(), 1'b1);

        // Maximum-size unicast frames walk commit_ptr up to 3FF0.
        for (int k = 0; k < 10; k++) begin
            build(MYMAC, 16'h88B5, 1500, 1'b0);
            exp_writes(1504);
            exp_done(1'b1, 1500);
            send(2 * frm.size(), 1'b1);
        end
        build(MYMAC, 16'h88B5, 1322, 1'b0);
        exp_writes(1326);
        exp_done(1'b1, 1322);
        send(2 * frm.size(), 1'b1);
        check("commit_pre_wrap", 64'(commit_ptr), 64'h3FF0);

        // Wrap: writes 3FF0..3FFF then 0000..0021.
        build(BCAST, 16'h88B5, 46, 1'b0);
        exp_writes(50);
        exp_done(1'b1, 46);
        send(128, 1'b1);
        check("commit_post_wrap", 64'(commit_ptr), 64'h001E);
        check("good_cnt_total",   64'(good_cnt),   64'd13);

        // Reset mid-payload after 20 payload bytes have been written.
        build(BCAST, 16'h88B5, 46, 1'b0);
        exp_writes(20);
        send(70, 1'b0);
        @(posedge rxclk);
        #2 rst_n = 1'b0;
        @(negedge rxclk);
        check_all_zero("midreset");
        check("midreset_writes_drained", 64'(wr_q.size()), 0);
        rxctl    = 1'b0;
        rxd      = '0;
        m_commit = 0;
        m_len    = 0;
        m_good   = 0;
        m_err    = 0;
        repeat (2) @(negedge rxclk);
        rst_n = 1'b1;
        repeat (4) @(negedge rxclk);

        build(BCAST, 16'h88B5, 46, 1'b0);
        exp_writes(50);
        exp_done(1'b1, 46);
        send(128, 1'b1);

        repeat (10) @(negedge rxclk);
        check("pending_writes", 64'(wr_q.size()),   0);
        check("pending_done",   64'(done_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
